status_led_driver: RTL

// - Parametrised LED/status driver: pLEDS channels, each with a per-channel display mode.
// - Per-channel pulse stretching and clock-alive (activity timeout) detection.
// - Global error flash override.
// - Sits in fe_clk domain under the board top; generalises the fixed led2/led3 select/error mux.
// - I_activity inputs are toggle/pulse signals from other clock domains (e.g. divided trace clock).

---
 rtl/status_led_driver_pkg.sv | 16 +
 rtl/led_channel.sv | 86 ++++++++
 rtl/status_led_driver.sv | 55 +++++
 3 files changed

// File: rtl/status_led_driver_pkg.sv
// Shared LED mode encodings and blink-pattern helpers for the status LED driver.
package status_led_driver_pkg;

    typedef enum logic [1:0] {
        LED_MODE_LEVEL     = 2'b00,
        LED_MODE_ACTIVITY  = 2'b01,
        LED_MODE_HEARTBEAT = 2'b10,
        LED_MODE_OFF       = 2'b11
    } led_mode_t;

    // Flash is lit for the last quarter of each blink period.
    function automatic logic flash_of(input logic msb, input logic msb_m1);
        return msb & msb_m1;
    endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: activity synchroniser, pulse stretcher, alive timeout,
// mode mux and registered LED/alive outputs.
module led_channel
    import status_led_driver_pkg::*;
#(
    parameter int pSTRETCH_BITS = 20,
    parameter int pALIVE_BITS   = 16
) (
    input  logic      fe_clk,
    input  logic      fpga_reset,
    input  led_mode_t i_mode,
    input  logic      i_level,
    input  logic      i_activity,
    input  logic      i_error_flag,
    input  logic      i_heartbeat,
    input  logic      i_flash,
    output logic      o_led,
    output logic      o_alive
);

    localparam logic [pSTRETCH_BITS-1:0] STRETCH_ONE = {{(pSTRETCH_BITS-1){1'b0}}, 1'b1};
    localparam logic [pALIVE_BITS-1:0]   ALIVE_ONE   = {{(pALIVE_BITS-1){1'b0}}, 1'b1};

    (* ASYNC_REG = "TRUE" *) logic r_sync1;
    (* ASYNC_REG = "TRUE" *) logic r_sync2;
    (* ASYNC_REG = "TRUE" *) logic r_sync3;

    logic [pSTRETCH_BITS-1:0] r_stretch_cnt;
    logic [pALIVE_BITS-1:0]   r_timeout_cnt;

    logic w_event;
    logic w_stretch;
    logic w_alive;
    logic w_led;

    always_comb begin
        w_event   = r_sync2 ^ r_sync3;
        w_stretch = (r_stretch_cnt != '0);
        w_alive   = (r_timeout_cnt != '1);
        w_led     = 1'b0;
        if (i_error_flag) begin
            w_led = i_flash;
        end else begin
            case (i_mode)
                LED_MODE_LEVEL:     w_led = i_level;
                LED_MODE_ACTIVITY:  w_led = w_stretch;
                LED_MODE_HEARTBEAT: w_led = i_heartbeat & w_alive;
                LED_MODE_OFF:       w_led = 1'b0;
                default:            w_led = 1'b0;
            endcase
        end
    end

    // A fresh event always wins over the counters reaching their end value.
    always_ff @(posedge fe_clk) begin
        if (fpga_reset) begin
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_sync3       <= 1'b0;
            r_stretch_cnt <= '0;
            r_timeout_cnt <= '1;
            o_led         <= 1'b0;
            o_alive       <= 1'b0;
        end else begin
            r_sync1 <= i_activity;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;

            if (w_event) begin
                r_stretch_cnt <= '1;
            end else if (w_stretch) begin
                r_stretch_cnt <= r_stretch_cnt - STRETCH_ONE;
            end

            if (w_event) begin
                r_timeout_cnt <= '0;
            end else if (w_alive) begin
                r_timeout_cnt <= r_timeout_cnt + ALIVE_ONE;
            end

            o_led   <= w_led;
            o_alive <= w_alive;
        end
    end

endmodule

// File: rtl/status_led_driver.sv
// Multi-channel status LED driver: shared blink counter plus one led_channel per LED.
module status_led_driver
    import status_led_driver_pkg::*;
#(
    parameter int pLEDS         = 4,
    parameter int pSTRETCH_BITS = 20,
    parameter int pALIVE_BITS   = 16,
    parameter int pBLINK_BITS   = 23
) (
    input  logic               fe_clk,
    input  logic               fpga_reset,
    input  logic [2*pLEDS-1:0] I_mode,
    input  logic [pLEDS-1:0]   I_level,
    input  logic [pLEDS-1:0]   I_activity,
    input  logic               I_error_flag,
    output logic [pLEDS-1:0]   O_led,
    output logic [pLEDS-1:0]   O_alive
);

    localparam logic [pBLINK_BITS-1:0] BLINK_ONE = {{(pBLINK_BITS-1){1'b0}}, 1'b1};

    logic [pBLINK_BITS-1:0] r_blink_cnt;
    logic                   w_heartbeat;
    logic                   w_flash;

    always_ff @(posedge fe_clk) begin
        if (fpga_reset) begin
            r_blink_cnt <= '0;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_ONE;
        end
    end

    assign w_heartbeat = r_blink_cnt[pBLINK_BITS-1];
    assign w_flash     = flash_of(r_blink_cnt[pBLINK_BITS-1], r_blink_cnt[pBLINK_BITS-2]);

    for (genvar g = 0; g < pLEDS; g++) begin : g_ch
        led_channel #(
            .pSTRETCH_BITS (pSTRETCH_BITS),
            .pALIVE_BITS   (pALIVE_BITS)
        ) u_ch (
            .fe_clk       (fe_clk),
            .fpga_reset   (fpga_reset),
            .i_mode       (led_mode_t'(I_mode[2*g +: 2])),
            .i_level      (I_level[g]),
            .i_activity   (I_activity[g]),
            .i_error_flag (I_error_flag),
            .i_heartbeat  (w_heartbeat),
            .i_flash      (w_flash),
            .o_led        (O_led[g]),
            .o_alive      (O_alive[g])
        );
    end

endmodule
